mac_cluster_seq: RTL and testbench

MAC_CLUSTER_SEQ -- requirements
Module: mac_cluster_seq

---
 rtl/mac_seq_pkg.sv | 20 ++
 rtl/mac_seq_perf.sv | 37 +++
 rtl/mac_cluster_seq.sv | 148 ++++++++++++++
 tb/tb_mac_cluster_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared widths, FSM state type and helpers for the MAC cluster sequencer.
package mac_seq_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PASS_W = 8;
    localparam int unsigned PERF_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StBubble,
        StDrain
    } state_e;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/mac_seq_perf.sv
// Saturating busy/stall cycle counters, cleared when a new job is accepted.
module mac_seq_perf
    import mac_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              busy,
    input  logic              stall,
    output logic [PERF_W-1:0] perf_busy,
    output logic [PERF_W-1:0] perf_stall
);

    logic [PERF_W-1:0] busy_q;
    logic [PERF_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else if (clear) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            if (busy) begin
                busy_q <= sat_inc(busy_q);
            end
            if (stall) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

    assign perf_busy  = busy_q;
    assign perf_stall = stall_q;

endmodule

// File: rtl/mac_cluster_seq.sv
// Job sequencer for the MAC cluster: pass-major beat walk with cache write-back.
// Define MAC_SEQ_PERF_EN to build the busy/stall performance counters.
module mac_cluster_seq
    import mac_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_num_out,
    input  logic [PASS_W-1:0] cfg_num_pass,
    input  logic              cfg_bias_en,
    input  logic              cfg_relu_en,
    input  logic              op_valid,
    output logic              op_ready,
    output logic              mac_en,
    output logic              mac_add_bias,
    output logic              mac_relu,
    output logic              mac_done,
    output logic              mac_cache_clear,
    output logic [ADDR_W-1:0] mac_rd_addr,
    output logic [ADDR_W-1:0] mac_wr_addr,
    output logic              mac_wr_en,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              job_done,
    output logic [PERF_W-1:0] perf_busy,
    output logic [PERF_W-1:0] perf_stall
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] num_out_q, addr_q, addr_d, wr_addr_q, out_addr_q;
    logic [PASS_W-1:0] num_pass_q, pass_q, pass_d;
    logic              bias_en_q, relu_en_q, wr_en_q, out_valid_q, job_done_q;
    logic              accept, beat, last_addr, last_pass, last_beat;

    assign accept    = (state_q == StIdle) & start;
    assign op_ready  = (state_q == StRun);
    assign beat      = op_valid & op_ready;
    assign last_addr = (addr_q == num_out_q);
    assign last_pass = (pass_q == num_pass_q);
    assign last_beat = last_addr & last_pass;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StRun;
                addr_d  = '0;
                pass_d  = '0;
            end
            StRun: begin
                if (beat) begin
                    if (last_beat) begin
                        state_d = StDrain;
                        addr_d  = '0;
                        pass_d  = '0;
                    end else begin
                        if (last_addr) begin
                            addr_d = '0;
                            pass_d = pass_q + PASS_W'(1);
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                        // Single output: next beat would read the entry still being written.
                        if (num_out_q == '0) begin
                            state_d = StBubble;
                        end
                    end
                end
            end
            StBubble: state_d = StRun;
            StDrain:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            pass_q      <= '0;
            num_out_q   <= '0;
            num_pass_q  <= '0;
            bias_en_q   <= 1'b0;
            relu_en_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            job_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            if (accept) begin
                num_out_q  <= cfg_num_out;
                num_pass_q <= cfg_num_pass;
                bias_en_q  <= cfg_bias_en;
                relu_en_q  <= cfg_relu_en;
            end
            wr_en_q     <= beat & ~last_pass;
            wr_addr_q   <= addr_q;
            out_valid_q <= beat & last_pass;
            out_addr_q  <= addr_q;
            job_done_q  <= (state_q == StDrain);
        end
    end

    assign mac_en          = beat;
    assign mac_add_bias    = beat & bias_en_q & (pass_q == '0);
    assign mac_done        = beat & last_pass;
    assign mac_relu        = beat & last_pass & relu_en_q;
    assign mac_cache_clear = (state_q != StClear);
    assign mac_rd_addr     = addr_q;
    assign mac_wr_addr     = wr_addr_q;
    assign mac_wr_en       = wr_en_q;
    assign out_valid       = out_valid_q;
    assign out_addr        = out_addr_q;
    assign busy            = (state_q != StIdle);
    assign job_done        = job_done_q;

`ifdef MAC_SEQ_PERF_EN
    logic stall;
    assign stall = ((state_q == StRun) & ~op_valid) | (state_q == StBubble);

    mac_seq_perf u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (accept),
        .busy       (busy),
        .stall      (stall),
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
    );
`else
    assign perf_busy  = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mac_cluster_seq.sv
// Randomized self-checking bench for mac_cluster_seq against a job-level beat model.
module tb_mac_cluster_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] cfg_num_out;
    logic [7:0] cfg_num_pass;
    logic       cfg_bias_en, cfg_relu_en, op_valid;
    logic       op_ready, mac_en, mac_add_bias, mac_relu, mac_done, mac_cache_clear;
    logic [4:0] mac_rd_addr, mac_wr_addr, out_addr;
    logic       mac_wr_en, out_valid, busy, job_done;
    logic [15:0] perf_busy, perf_stall;

    int total = 0;
    int bad   = 0;
    int gap_plan[$];

    mac_cluster_seq dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .cfg_num_out     (cfg_num_out),
        .cfg_num_pass    (cfg_num_pass),
        .cfg_bias_en     (cfg_bias_en),
        .cfg_relu_en     (cfg_relu_en),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .mac_en          (mac_en),
        .mac_add_bias    (mac_add_bias),
        .mac_relu        (mac_relu),
        .mac_done        (mac_done),
        .mac_cache_clear (mac_cache_clear),
        .mac_rd_addr     (mac_rd_addr),
        .mac_wr_addr     (mac_wr_addr),
        .mac_wr_en       (mac_wr_en),
        .out_valid       (out_valid),
        .out_addr        (out_addr),
        .busy            (busy),
        .job_done        (job_done),
        .perf_busy       (perf_busy),
        .perf_stall      (perf_stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_gaps(input int beats, input int max_gap);
        gap_plan.delete();
        for (int i = 0; i < beats; i++) gap_plan.push_back(int'($urandom_range(0, max_gap)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(job_done), 0);
        check_eq({tag, "_ready"}, 32'(op_ready), 0);
        check_eq({tag, "_en"}, 32'(mac_en), 0);
        check_eq({tag, "_wr_en"}, 32'(mac_wr_en), 0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_ctl"}, 32'({mac_done, mac_relu, mac_add_bias}), 0);
        check_eq({tag, "_addrs"}, 32'({mac_rd_addr, mac_wr_addr, out_addr}), 0);
        check_eq({tag, "_clear_n"}, 32'(mac_cache_clear), 1);
        check_eq({tag, "_perf"}, 32'({perf_busy, perf_stall}), 0);
    endtask

    // Runs one job; gap_plan[k] idle RUN cycles precede beat k.
    task automatic run_job(input int n, input int p, input bit bias, input bit relu,
                           input bit poke);
        int beats   = n * p;
        int bubbles = (n == 1) ? p - 1 : 0;
        int gsum    = 0;
        int t_done, k, g, exp_pass, exp_addr, prev_addr, exp_pb, exp_ps;
        bit beat, prev_beat, prev_last;
        for (int i = 0; i < beats; i++) gsum += gap_plan[i];
        t_done    = 3 + beats + gsum + bubbles;
        k         = 0;
        g         = gap_plan[0];
        prev_beat = 1'b0;
        prev_last = 1'b0;
        prev_addr = 0;

        @(posedge clk); #1;
        start        = 1'b1;
        cfg_num_out  = 5'(n - 1);
        cfg_num_pass = 8'(p - 1);
        cfg_bias_en  = bias;
        cfg_relu_en  = relu;
        op_valid     = 1'($urandom);
        #1;
        check_eq("idle_busy", 32'(busy), 0);
        check_eq("idle_ready", 32'(op_ready), 0);

        for (int c = 1; c <= t_done + 1; c++) begin
            @(posedge clk); #1;
            start        = poke && (c == 3);
            cfg_num_out  = 5'($urandom);
            cfg_num_pass = 8'($urandom);
            cfg_bias_en  = 1'($urandom);
            cfg_relu_en  = 1'($urandom);
            if (op_ready && k < beats) op_valid = (g == 0);
            else op_valid = 1'($urandom);
            #1;
            beat = op_valid && op_ready && (k < beats);
            check_eq("mac_en", 32'(mac_en), 32'(op_valid && op_ready));
            check_eq("cache_clear_n", 32'(mac_cache_clear), 32'(c != 1));
            check_eq("busy", 32'(busy), 32'(c < t_done));
            check_eq("job_done", 32'(job_done), 32'(c == t_done));
            if (c == 1 || c >= t_done - 1) check_eq("ready_outside_run", 32'(op_ready), 0);
            if (op_ready && k >= beats) check_eq("ready_after_last", 32'(op_ready), 0);
            check_eq("wr_en", 32'(mac_wr_en), 32'(prev_beat && !prev_last));
            if (prev_beat && !prev_last) check_eq("wr_addr", 32'(mac_wr_addr), 32'(prev_addr));
            check_eq("out_valid", 32'(out_valid), 32'(prev_beat && prev_last));
            if (prev_beat && prev_last) check_eq("out_addr", 32'(out_addr), 32'(prev_addr));
            if (beat) begin
                exp_pass = k / n;
                exp_addr = k % n;
                check_eq("rd_addr", 32'(mac_rd_addr), 32'(exp_addr));
                check_eq("add_bias", 32'(mac_add_bias), 32'(bias && exp_pass == 0));
                check_eq("mac_done", 32'(mac_done), 32'(exp_pass == p - 1));
                check_eq("mac_relu", 32'(mac_relu), 32'(relu && exp_pass == p - 1));
                check_eq("raw_hazard", 32'(mac_wr_en && mac_wr_addr == mac_rd_addr), 0);
                prev_addr = exp_addr;
                prev_last = (exp_pass == p - 1);
                k++;
                g = (k < beats) ? gap_plan[k] : 0;
            end else begin
                check_eq("ctl_idle", 32'({mac_done, mac_relu, mac_add_bias}), 0);
                if (op_ready && k < beats && g > 0) g--;
            end
            prev_beat = beat;
        end
        start = 1'b0;
        check_eq("beat_count", 32'(k), 32'(beats));
`ifdef MAC_SEQ_PERF_EN
        exp_pb = t_done - 1;
        exp_ps = gsum + bubbles;
`else
        exp_pb = 0;
        exp_ps = 0;
`endif
        check_eq("perf_busy", 32'(perf_busy), 32'(exp_pb));
        check_eq("perf_stall", 32'(perf_stall), 32'(exp_ps));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        cfg_num_out  = '0;
        cfg_num_pass = '0;
        cfg_bias_en  = 1'b0;
        cfg_relu_en  = 1'b0;
        op_valid     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        fill_gaps(12, 0);
        run_job(4, 3, 1'b0, 1'b0, 1'b0);
        fill_gaps(2, 0);
        run_job(1, 2, 1'b0, 1'b0, 1'b0);
        gap_plan = '{0, 2, 0, 0};
        run_job(2, 2, 1'b0, 1'b0, 1'b0);
        fill_gaps(8, 0);
        run_job(4, 2, 1'b1, 1'b1, 1'b0);
        fill_gaps(12, 1);
        run_job(4, 3, 1'b1, 1'b0, 1'b1);
        fill_gaps(1, 0);
        run_job(1, 1, 1'b1, 1'b1, 1'b0);
        fill_gaps(64, 1);
        run_job(32, 2, 1'b1, 1'b1, 1'b1);
        fill_gaps(256, 0);
        run_job(1, 256, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of RUN, then a clean job.
        @(posedge clk); #1;
        start        = 1'b1;
        cfg_num_out  = 5'd3;
        cfg_num_pass = 8'd2;
        op_valid     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        @(posedge clk); #1;
        check_reset_outputs("held_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_done", 32'(job_done), 0);
        fill_gaps(12, 1);
        run_job(4, 3, 1'b1, 1'b1, 1'b0);

        for (int j = 0; j < 10; j++) begin
            int n, p;
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(9, 32))
                                            : int'($urandom_range(1, 8));
            p = int'($urandom_range(1, 5));
            fill_gaps(n * p, int'($urandom_range(0, 3)));
            run_job(n, p, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
